// File: rtl/mem_loader.sv
// Command-queue front end for a simple memory/IO bus: commands are buffered
// in a small FIFO, checked for alignment, executed one at a time, and answered in order.
module mem_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int READ_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_mode,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic [7:0]  err_count,
  input  logic [31:0] memData,
  output logic        MemWrite,
  output logic [1:0]  MemMode,
  output logic [31:0] writeMemData,
  output logic [15:0] memAddr,
  output logic [2:0]  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_RESP  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  mode;
    logic [15:0] addr;
    logic [31:0] data;
  } cmd_t;

  // Handshake: a command is taken on a rising edge where cmd_valid and
  // cmd_ready are both 1; responses are single-cycle pulses with no backpressure.

  cmd_t          fifo_q [FIFO_DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic          fifo_empty, fifo_full, push, pop;
  cmd_t          head;

  state_t        state_q, state_d;
  cmd_t          cur_q, cur_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [31:0]   cap_q, cap_d;
  logic [7:0]    err_q, err_d;

  function automatic logic misaligned(input cmd_t c);
    return (c.mode == 2'b11) ||
           (c.mode == 2'b00 && c.addr[1:0] != 2'b00) ||
           (c.mode == 2'b01 && c.addr[0]);
  endfunction

  // Pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push       = cmd_valid && !fifo_full;
  assign head       = fifo_q[rptr_q[AW-1:0]];
  assign cmd_ready  = !fifo_full;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q[AW-1:0]] <= '{write: cmd_write, mode: cmd_mode,
                                  addr: cmd_addr, data: cmd_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      state_q <= S_IDLE;
      cur_q   <= '0;
      lat_q   <= '0;
      cap_q   <= '0;
      err_q   <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      state_q <= state_d;
      cur_q   <= cur_d;
      lat_q   <= lat_d;
      cap_q   <= cap_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    lat_d        = lat_q;
    cap_d        = cap_q;
    err_d        = err_q;
    pop          = 1'b0;
    rsp_valid    = 1'b0;
    rsp_err      = 1'b0;
    rsp_data     = '0;
    MemWrite     = 1'b0;
    MemMode      = '0;
    memAddr      = '0;
    writeMemData = '0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop   = 1'b1;
          cur_d = head;
          lat_d = '0;
          if (misaligned(head))  state_d = S_ERR;
          else if (head.write)   state_d = S_WRITE;
          else                   state_d = S_READ;
        end
      end
      S_WRITE: begin
        MemWrite     = 1'b1;
        MemMode      = cur_q.mode;
        memAddr      = cur_q.addr;
        writeMemData = cur_q.data;
        rsp_valid    = 1'b1;
        state_d      = S_IDLE;
      end
      S_READ: begin
        MemMode = cur_q.mode;
        memAddr = cur_q.addr;
        // Address is held for READ_LAT cycles; data is taken on the last edge.
        if (lat_q == LW'(READ_LAT - 1)) begin
          cap_d   = memData;
          state_d = S_RESP;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        case (cur_q.mode)
          2'b00:   rsp_data = cap_q;
          2'b01:   rsp_data = {16'h0, cap_q[15:0]};
          default: rsp_data = {24'h0, cap_q[7:0]};
        endcase
        state_d = S_IDLE;
      end
      S_ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        if (err_q != 8'hFF) err_d = err_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = !fifo_empty || (state_q != S_IDLE);
  assign err_count = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: one instance with READ_LAT=1 and one with
// READ_LAT=8, responses checked in order against a queue of expected results.
module tb_mem_loader;

  typedef struct packed {
    logic        is_wr;
    logic        err;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] wdata;
  } exp_t;

  logic        clk, reset;
  logic        cmd_valid1, cmd_valid8, cmd_write;
  logic [1:0]  cmd_mode;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data, memData;

  logic        ready1, rsp_valid1, rsp_err1, busy1, mw1;
  logic [31:0] rsp_data1, wmd1;
  logic [7:0]  errc1;
  logic [1:0]  mm1;
  logic [15:0] ma1;
  logic [2:0]  st1;

  logic        ready8, rsp_valid8, rsp_err8, busy8, mw8;
  logic [31:0] rsp_data8, wmd8;
  logic [7:0]  errc8;
  logic [1:0]  mm8;
  logic [15:0] ma8;
  logic [2:0]  st8;

  exp_t exp_q1[$];
  exp_t exp_q8[$];
  exp_t mon_e1, mon_e8;
  int n_vec = 0, n_miss = 0;
  int wr_cnt1 = 0, rsp_cnt8 = 0;
  int wr0, r0;

  mem_loader #(.FIFO_DEPTH(4), .READ_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(ready1),
    .cmd_write(cmd_write), .cmd_mode(cmd_mode), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid1), .rsp_err(rsp_err1),
    .rsp_data(rsp_data1), .busy(busy1), .err_count(errc1), .memData(memData),
    .MemWrite(mw1), .MemMode(mm1), .writeMemData(wmd1), .memAddr(ma1),
    .dbg_state(st1)
  );

  mem_loader #(.FIFO_DEPTH(4), .READ_LAT(8)) u_dut8 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid8), .cmd_ready(ready8),
    .cmd_write(cmd_write), .cmd_mode(cmd_mode), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid8), .rsp_err(rsp_err8),
    .rsp_data(rsp_data8), .busy(busy8), .err_count(errc8), .memData(memData),
    .MemWrite(mw8), .MemMode(mm8), .writeMemData(wmd8), .memAddr(ma8),
    .dbg_state(st8)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic w, input logic [1:0] m, input logic [15:0] a,
                                 input logic [31:0] d, input logic [31:0] mem);
    exp_t e;
    e = '0;
    e.addr  = a;
    e.wdata = d;
    if (m == 2'b11 || (m == 2'b00 && a[1:0] != 2'b00) || (m == 2'b01 && a[0])) e.err = 1'b1;
    else if (w) e.is_wr = 1'b1;
    else begin
      case (m)
        2'b00:   e.data = mem;
        2'b01:   e.data = {16'h0, mem[15:0]};
        default: e.data = {24'h0, mem[7:0]};
      endcase
    end
    return e;
  endfunction

  // Driver: present a command, wait (bounded) for ready, push expectation.
  task automatic push(input int d, input logic w, input logic [1:0] m,
                      input logic [15:0] a, input logic [31:0] dat);
    int guard;
    logic rdy;
    @(negedge clk);
    cmd_write = w; cmd_mode = m; cmd_addr = a; cmd_data = dat;
    if (d == 1) cmd_valid1 = 1'b1; else cmd_valid8 = 1'b1;
    guard = 0;
    rdy = (d == 1) ? ready1 : ready8;
    while (!rdy && guard < 100) begin
      @(negedge clk);
      guard++;
      rdy = (d == 1) ? ready1 : ready8;
    end
    check("push ready", 32'(rdy), 32'd1);
    if (d == 1) exp_q1.push_back(model(w, m, a, dat, memData));
    else        exp_q8.push_back(model(w, m, a, dat, memData));
    @(posedge clk);
    #1;
    cmd_valid1 = 1'b0;
    cmd_valid8 = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int guard;
    guard = 0;
    @(negedge clk);
    while (((d == 1) ? busy1 : busy8) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("idle timeout", 32'(guard < 1000), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_rsp(input string p, input exp_t e, input logic err, input logic [31:0] data,
                           input logic mw, input logic [15:0] addr, input logic [31:0] wdata);
    check({p, " rsp_err"}, 32'(err), 32'(e.err));
    check({p, " rsp_data"}, data, e.data);
    check({p, " MemWrite"}, 32'(mw), 32'(e.is_wr));
    if (e.is_wr) begin
      check({p, " memAddr"}, 32'(addr), 32'(e.addr));
      check({p, " writeMemData"}, wdata, e.wdata);
    end else if (e.err) begin
      check({p, " err memAddr"}, 32'(addr), 32'd0);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (mw1) wr_cnt1++;
    if (!reset && rsp_valid1) begin
      check("dut1 rsp expected", 32'(exp_q1.size() != 0), 32'd1);
      if (exp_q1.size() != 0) begin
        mon_e1 = exp_q1.pop_front();
        check_rsp("dut1", mon_e1, rsp_err1, rsp_data1, mw1, ma1, wmd1);
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid8) rsp_cnt8++;
    if (!reset && rsp_valid8) begin
      check("dut8 rsp expected", 32'(exp_q8.size() != 0), 32'd1);
      if (exp_q8.size() != 0) begin
        mon_e8 = exp_q8.pop_front();
        check_rsp("dut8", mon_e8, rsp_err8, rsp_data8, mw8, ma8, wmd8);
      end
    end
  end

  initial begin
    reset = 1'b1;
    cmd_valid1 = 1'b0; cmd_valid8 = 1'b0; cmd_write = 1'b0;
    cmd_mode = '0; cmd_addr = '0; cmd_data = '0; memData = '0;
    repeat (3) @(negedge clk);
    check("reset cmd_ready", 32'(ready1), 32'd1);
    check("reset busy", 32'(busy1), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid1), 32'd0);
    check("reset err_count", 32'(errc1), 32'd0);
    check("reset MemWrite", 32'(mw1), 32'd0);
    check("reset state", 32'(st1), 32'd0);
    reset = 1'b0;

    // Write word with latency check
    push(1, 1'b1, 2'b00, 16'h0010, 32'hDEADBEEF);
    @(negedge clk);
    check("idle cycle rsp_valid", 32'(rsp_valid1), 32'd0);
    check("idle cycle memAddr", 32'(ma1), 32'd0);
    check("idle cycle writeMemData", wmd1, 32'd0);
    @(negedge clk);
    check("write strobe", 32'(mw1), 32'd1);
    check("write rsp_valid", 32'(rsp_valid1), 32'd1);
    @(negedge clk);
    check("write strobe single", 32'(mw1), 32'd0);

    // Reads of each size
    memData = 32'h123456A5;
    wr0 = wr_cnt1;
    push(1, 1'b0, 2'b10, 16'h0003, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("read memAddr", 32'(ma1), 32'h0003);
    check("read MemMode", 32'(mm1), 32'd2);
    @(negedge clk);
    check("read rsp_valid", 32'(rsp_valid1), 32'd1);
    check("read byte data", rsp_data1, 32'h000000A5);
    push(1, 1'b0, 2'b01, 16'h0002, 32'h0);
    push(1, 1'b0, 2'b00, 16'h0004, 32'h0);
    wait_idle(1);
    check("reads no MemWrite", 32'(wr_cnt1 - wr0), 32'd0);

    // Errors and saturation
    wr0 = wr_cnt1;
    push(1, 1'b0, 2'b00, 16'h0002, 32'h0);
    push(1, 1'b1, 2'b11, 16'h0020, 32'h55);
    wait_idle(1);
    check("err_count two", 32'(errc1), 32'd2);
    check("errors no MemWrite", 32'(wr_cnt1 - wr0), 32'd0);
    push(1, 1'b0, 2'b01, 16'h0001, 32'h0);
    for (int i = 0; i < 257; i++) push(1, 1'(i), 2'b11, 16'(i), 32'(i));
    wait_idle(1);
    check("err_count saturated", 32'(errc1), 32'd255);
    check("dut1 queue drained", 32'(exp_q1.size()), 32'd0);

    // Full FIFO behind a long read
    memData = 32'hCAFE1234;
    push(8, 1'b0, 2'b00, 16'h0100, 32'h0);
    push(8, 1'b1, 2'b00, 16'h0104, 32'h11112222);
    push(8, 1'b0, 2'b01, 16'h0102, 32'h0);
    push(8, 1'b0, 2'b00, 16'h0101, 32'h0);
    @(negedge clk);
    check("ready with 3 queued", 32'(ready8), 32'd1);
    push(8, 1'b0, 2'b10, 16'h0107, 32'h0);
    @(negedge clk);
    check("ready with 4 queued", 32'(ready8), 32'd0);
    check("busy while full", 32'(busy8), 32'd1);
    push(8, 1'b1, 2'b00, 16'h0200, 32'hA5A5A5A5);
    wait_idle(8);
    check("dut8 queue drained", 32'(exp_q8.size()), 32'd0);
    check("dut8 err_count", 32'(errc8), 32'd1);

    // Reset during a read with two commands queued
    push(8, 1'b0, 2'b00, 16'h0300, 32'h0);
    push(8, 1'b1, 2'b00, 16'h0304, 32'h1);
    push(8, 1'b1, 2'b00, 16'h0308, 32'h2);
    @(negedge clk);
    check("in READ before reset", 32'(st8), 32'd2);
    r0 = rsp_cnt8;
    #1 reset = 1'b1;
    #1;
    check("rst MemWrite", 32'(mw8), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid8), 32'd0);
    check("rst rsp_err", 32'(rsp_err8), 32'd0);
    check("rst rsp_data", rsp_data8, 32'd0);
    check("rst memAddr", 32'(ma8), 32'd0);
    check("rst MemMode", 32'(mm8), 32'd0);
    check("rst writeMemData", wmd8, 32'd0);
    check("rst busy", 32'(busy8), 32'd0);
    check("rst err_count", 32'(errc8), 32'd0);
    check("rst cmd_ready", 32'(ready8), 32'd1);
    exp_q8.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("no rsp after reset", 32'(rsp_cnt8 - r0), 32'd0);
    push(8, 1'b1, 2'b00, 16'h0400, 32'h0BADF00D);
    wait_idle(8);
    check("post-reset write rsp", 32'(rsp_cnt8 - r0), 32'd1);
    check("post-reset queue drained", 32'(exp_q8.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter FIFO_DEPTH, 4, command FIFO entries (power of two, >=2) SHALL be supported.
REQ-002 Parameter READ_LAT, 1, cycles memAddr is held before memData is sampled (>=1) SHALL be supported.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command FIFO not full.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_mode  input  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved.
REQ-009 cmd_addr  input  16  byte address.
REQ-010 cmd_data  input  32  write data, right-aligned.
REQ-011 rsp_valid  output  1  one-cycle response pulse, no backpressure.
REQ-012 rsp_err  output  1  response is an error; qualified by rsp_valid.
REQ-013 rsp_data  output  32  read data, zero-extended; 0 for writes and errors.
REQ-014 busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-015 err_count  output  8  saturating count of error responses.
REQ-016 memData  input  32  bus read data from the memory/IO responder.
REQ-017 MemWrite  output  1  bus write strobe.
REQ-018 MemMode  output  2  bus access size, same encoding as cmd_mode.
REQ-019 writeMemData  output  32  bus write data.
REQ-020 memAddr  output  16  bus byte address.

Function
REQ-021 A command SHALL be pushed on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_ready SHALL be 0 exactly when the FIFO holds FIFO_DEPTH entries.
REQ-022 Push and pop in the same cycle SHALL both take effect; the FIFO has no bypass, so an empty-FIFO push is popped no earlier than the next edge.
REQ-023 FSM states SHALL be IDLE, WRITE, READ, RESP, ERR.
REQ-024 IDLE: FIFO non-empty -> pop the head; misaligned (word with addr[1:0]!=0, half with addr[0]!=0) or mode 11 -> ERR; else write -> WRITE; else read -> READ.
REQ-025 WRITE: exactly one cycle with MemWrite=1, memAddr/MemMode/writeMemData from the command; rsp_valid=1, rsp_err=0 in the same cycle; -> IDLE.
REQ-026 READ: MemWrite=0, memAddr/MemMode held for READ_LAT cycles; memData captured at the edge ending the last READ cycle; -> RESP.
REQ-027 RESP: one cycle with rsp_valid=1, rsp_err=0; rsp_data = captured word (word), captured[15:0] (half) or captured[7:0] (byte), zero-extended; -> IDLE.
REQ-028 ERR: one cycle with rsp_valid=1, rsp_err=1, rsp_data=0, no bus access (MemWrite=0); err_count increments, saturating at 255; -> IDLE.
REQ-029 In IDLE, MemWrite, MemMode, memAddr and writeMemData SHALL all be 0.
REQ-030 Latency from push edge: write strobe and response one cycle after the next edge; read response READ_LAT+1 cycles after the first READ cycle; per-command cost is 2 cycles (write/error) and READ_LAT+2 cycles (read), including the IDLE cycle.
REQ-031 Responses SHALL be issued in command order, exactly one per accepted command.

Reset
REQ-032 Reset assertion SHALL immediately force MemWrite=0, rsp_valid=0, rsp_err=0, rsp_data=0, bus outputs=0, busy=0, err_count=0, FSM=IDLE and FIFO empty; cmd_ready=1.
REQ-033 Reset mid-operation SHALL drop any in-flight and queued command with no response; the first command after deassertion SHALL behave as from power-up.

Verification
REQ-034 Write word: cmd(write, mode 00, addr 0x0010, data 0xDEADBEEF) -> one MemWrite=1 cycle with memAddr=0x0010, writeMemData=0xDEADBEEF; rsp_valid=1, rsp_err=0 in the same cycle.
REQ-035 Read byte, READ_LAT=1: memData=0x123456A5, cmd(read, mode 10, addr 0x0003) -> RESP pulse with rsp_data=0x000000A5, MemWrite never high.
REQ-036 Misaligned: cmd(read, mode 00, addr 0x0002) and cmd(write, mode 11) -> two rsp_err=1 pulses, no bus activity, err_count=2; 260 errors -> err_count=255.
REQ-037 Full FIFO: push 5 commands while the FSM is stalled in a READ with READ_LAT=8 -> cmd_ready=0 after the fourth queued entry; all responses arrive in order.
REQ-038 Reset during READ with 2 queued commands -> outputs zero immediately, busy=0, no responses afterward; a new write then completes normally.
